// File: rtl/mem_rd_arbiter_pkg.sv
// Shared encodings for the cache read-channel arbiter.
package mem_rd_arbiter_pkg;

  localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
  localparam logic [2:0] RD_TYPE_HALF = 3'b001;
  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  localparam logic [3:0] ID_IC_DEF    = 4'd0;
  localparam logic [3:0] ID_DC_DEF    = 4'd1;
  localparam logic [7:0] LINE_LEN_DEF = 8'd3;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_ADDR = 1'b1
  } ar_state_e;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
  } ar_fmt_t;

  // Cache lines are bursts of words; everything else is a single beat of the natural size.
  function automatic ar_fmt_t ar_encode(input logic [2:0] rd_type, input logic [7:0] line_len);
    ar_fmt_t f;
    if (rd_type == RD_TYPE_LINE) begin
      f.len  = line_len;
      f.size = 3'd2;
    end else begin
      f.len  = 8'd0;
      f.size = {1'b0, rd_type[1:0]};
    end
    return f;
  endfunction

endpackage

// File: rtl/mem_rd_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 = I-cache, bit 1 = D-cache.
module rr_arb2
  import mem_rd_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  logic prio_q, prio_d;  // 1: D-cache has priority on a tie

  // Grant: a lone requester wins, a tie goes to the priority side.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  // After an actual grant, priority passes to the side that did not win.
  always_comb begin
    prio_d = prio_q;
    if (grant_en && (gnt != 2'b00)) begin
      prio_d = gnt[0];
    end
  end

  // Priority register, D-cache first out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b1;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one AXI AR/R channel between I-cache and D-cache reads; one AR in flight at a
// time, at most one outstanding read per cache, R beats routed back by rid.
module mem_rd_arbiter
  import mem_rd_arbiter_pkg::*;
#(
  parameter logic [7:0] LINE_LEN = LINE_LEN_DEF,
  parameter logic [3:0] ID_IC    = ID_IC_DEF,
  parameter logic [3:0] ID_DC    = ID_DC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_rd_req,
  input  logic [2:0]  ic_rd_type,
  input  logic [31:0] ic_rd_addr,
  output logic        ic_rd_rdy,
  output logic        ic_ret_valid,
  output logic        ic_ret_last,
  output logic [31:0] ic_ret_data,
  input  logic        dc_rd_req,
  input  logic [2:0]  dc_rd_type,
  input  logic [31:0] dc_rd_addr,
  output logic        dc_rd_rdy,
  output logic        dc_ret_valid,
  output logic        dc_ret_last,
  output logic [31:0] dc_ret_data,
  output logic [3:0]  arid,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  ar_state_e   state_q, state_d;
  logic [3:0]  arid_q, arid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [1:0]  busy_q, busy_d;   // bit 0 = I-cache, bit 1 = D-cache

  logic        idle;
  logic [1:0]  arb_req, gnt;
  logic        hit_ic, hit_dc;
  ar_fmt_t     fmt;

  assign idle    = (state_q == AR_IDLE);
  assign arb_req = idle ? ({dc_rd_req, ic_rd_req} & ~busy_q) : 2'b00;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (arb_req),
    .grant_en (idle),
    .gnt      (gnt)
  );

  assign ic_rd_rdy = gnt[0] & ~rst;
  assign dc_rd_rdy = gnt[1] & ~rst;

  assign arvalid = (state_q == AR_ADDR);
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;

  // R demux: a beat is delivered only to a cache that actually has a read outstanding.
  assign rready       = ~rst;
  assign hit_ic       = rvalid & (rid == ID_IC) & busy_q[0];
  assign hit_dc       = rvalid & (rid == ID_DC) & busy_q[1];
  assign ic_ret_valid = hit_ic & ~rst;
  assign ic_ret_last  = rlast;
  assign ic_ret_data  = rdata;
  assign dc_ret_valid = hit_dc & ~rst;
  assign dc_ret_last  = rlast;
  assign dc_ret_data  = rdata;

  // AR FSM next state: latch the winner's request in IDLE, hold it in ADDR until arready.
  always_comb begin
    state_d  = state_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arsize_d = arsize_q;
    fmt      = ar_encode(gnt[1] ? dc_rd_type : ic_rd_type, LINE_LEN);
    case (state_q)
      AR_IDLE: begin
        if (gnt != 2'b00) begin
          arid_d   = gnt[1] ? ID_DC : ID_IC;
          araddr_d = gnt[1] ? dc_rd_addr : ic_rd_addr;
          arlen_d  = fmt.len;
          arsize_d = fmt.size;
          state_d  = AR_ADDR;
        end
      end
      AR_ADDR: begin
        if (arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  // Busy flags: set when the AR handshakes, cleared by the last R beat of that read.
  always_comb begin
    busy_d = busy_q;
    if (hit_ic && rlast) busy_d[0] = 1'b0;
    if (hit_dc && rlast) busy_d[1] = 1'b0;
    if ((state_q == AR_ADDR) && arready) begin
      if (arid_q == ID_DC) busy_d[1] = 1'b1;
      else                 busy_d[0] = 1'b1;
    end
  end

  // State, AR output and busy registers; reset abandons any in-flight AR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= AR_IDLE;
      arid_q   <= 4'd0;
      araddr_q <= 32'd0;
      arlen_q  <= 8'd0;
      arsize_q <= 3'd0;
      busy_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      arid_q   <= arid_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arsize_q <= arsize_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Scoreboard bench for mem_rd_arbiter: expected AR handshakes and return beats are
// queued by the stimulus and checked by a negedge monitor.
module tb_mem_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_rd_req = 1'b0, dc_rd_req = 1'b0;
  logic [2:0]  ic_rd_type = 3'd0, dc_rd_type = 3'd0;
  logic [31:0] ic_rd_addr = 32'd0, dc_rd_addr = 32'd0;
  logic        ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic        dc_rd_rdy, dc_ret_valid, dc_ret_last;
  logic [31:0] ic_ret_data, dc_ret_data;
  logic [3:0]  arid;
  logic        arvalid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = 32'd0;
  logic        rlast = 1'b0, rvalid = 1'b0;
  logic        rready;

  always #5 clk = ~clk;

  mem_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
    .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
    .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
    .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
    .dc_ret_data(dc_ret_data),
    .arid(arid), .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  ar_t         ar_q[$];
  logic [32:0] ic_q[$];
  logic [32:0] dc_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  ar_t         mon_ar, got_ar;
  logic [32:0] mon_ret;

  function automatic ar_t mk_ar(input logic [3:0] id, input logic [31:0] a,
                                input logic [7:0] l, input logic [2:0] s);
    ar_t r;
    r.id = id; r.addr = a; r.len = l; r.size = s;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every AR handshake and every return beat must match the next queued entry.
  always @(negedge clk) begin
    if (arvalid && arready) begin
      vectors++;
      got_ar = mk_ar(arid, araddr, arlen, arsize);
      if (ar_q.size() == 0) begin
        miscompares++;
        $display("FAIL ar_unexpected: got %0h expected none", got_ar);
      end else begin
        mon_ar = ar_q.pop_front();
        if (got_ar !== mon_ar) begin
          miscompares++;
          $display("FAIL ar_fields: got %0h expected %0h", got_ar, mon_ar);
        end
      end
    end
    if (ic_ret_valid) begin
      vectors++;
      if (ic_q.size() == 0) begin
        miscompares++;
        $display("FAIL ic_ret_unexpected: got data %0h last %0b expected none", ic_ret_data, ic_ret_last);
      end else begin
        mon_ret = ic_q.pop_front();
        if ({ic_ret_last, ic_ret_data} !== mon_ret) begin
          miscompares++;
          $display("FAIL ic_ret: got %0h expected %0h", {ic_ret_last, ic_ret_data}, mon_ret);
        end
      end
    end
    if (dc_ret_valid) begin
      vectors++;
      if (dc_q.size() == 0) begin
        miscompares++;
        $display("FAIL dc_ret_unexpected: got data %0h last %0b expected none", dc_ret_data, dc_ret_last);
      end else begin
        mon_ret = dc_q.pop_front();
        if ({dc_ret_last, dc_ret_data} !== mon_ret) begin
          miscompares++;
          $display("FAIL dc_ret: got %0h expected %0h", {dc_ret_last, dc_ret_data}, mon_ret);
        end
      end
    end
  end

  // Present a request and hold it until rdy; optionally expect the AR it produces.
  task automatic request(input bit dc, input logic [2:0] t, input logic [31:0] a,
                         input bit expect_hs, input ar_t exp);
    int n;
    if (dc) begin dc_rd_req = 1'b1; dc_rd_type = t; dc_rd_addr = a; end
    else    begin ic_rd_req = 1'b1; ic_rd_type = t; ic_rd_addr = a; end
    #1;
    n = 0;
    while (!(dc ? dc_rd_rdy : ic_rd_rdy) && n < 20) begin
      tick();
      n++;
    end
    chk(dc ? "dc_rd_rdy" : "ic_rd_rdy", dc ? dc_rd_rdy : ic_rd_rdy, 1);
    if (expect_hs) ar_q.push_back(exp);
    tick();
    if (dc) dc_rd_req = 1'b0;
    else    ic_rd_req = 1'b0;
  endtask

  // Wait for arvalid, stall `delay` cycles, then complete the handshake.
  task automatic ar_accept(input int delay);
    int n;
    n = 0;
    while (!arvalid && n < 20) begin
      tick();
      n++;
    end
    chk("arvalid_wait", arvalid, 1);
    repeat (delay) tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  // to: 0 = must be dropped, 1 = I-cache, 2 = D-cache.
  task automatic r_drive(input logic [3:0] id, input logic [31:0] d, input bit l, input int to);
    rid = id; rdata = d; rlast = l; rvalid = 1'b1;
    if (to == 1) ic_q.push_back({l, d});
    if (to == 2) dc_q.push_back({l, d});
  endtask

  task automatic r_idle();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input bit l, input int to);
    r_drive(id, d, l, to);
    tick();
    r_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, with both caches requesting.
    ic_rd_req = 1'b1; dc_rd_req = 1'b1;
    repeat (3) tick();
    chk("rst_ic_rdy", ic_rd_rdy, 0);
    chk("rst_dc_rdy", dc_rd_rdy, 0);
    chk("rst_rready", rready, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_ar_fields", {arid, araddr, arlen, arsize}, 47'd0);
    ic_rd_req = 1'b0; dc_rd_req = 1'b0;
    rst = 1'b0;
    tick();
    chk("rready_out_of_rst", rready, 1);

    // I-cache line read, arready after 2 cycles, 4 beats.
    request(0, 3'b100, 32'h1C00_0000, 1, mk_ar(4'd0, 32'h1C00_0000, 8'd3, 3'd2));
    chk("t1_arvalid_next", arvalid, 1);
    chk("t1_no_rdy_in_addr", ic_rd_rdy, 0);
    ar_accept(2);
    r_beat(4'd0, 32'hA000_0000, 0, 1);
    r_beat(4'd0, 32'hA000_0001, 0, 1);
    r_beat(4'd0, 32'hA000_0002, 0, 1);
    r_beat(4'd0, 32'hA000_0003, 1, 1);

    // Stray beats: rid=0 with nothing outstanding, and an unknown rid=2.
    r_drive(4'd0, 32'h5555_0000, 1, 0);
    #1;
    chk("t5_rready", rready, 1);
    chk("t5_no_ic_ret", ic_ret_valid, 0);
    tick();
    r_idle();
    r_drive(4'd2, 32'h5555_0002, 1, 0);
    #1;
    chk("t5_rid2_no_ret", {ic_ret_valid, dc_ret_valid}, 2'b00);
    tick();
    r_idle();

    // D-cache byte read from an odd address.
    request(1, 3'b000, 32'h0000_0003, 1, mk_ar(4'd1, 32'h0000_0003, 8'd0, 3'd0));
    ar_accept(1);
    r_beat(4'd1, 32'h0000_00EE, 1, 2);

    // I-cache outstanding; second I-cache request waits, D-cache gets through.
    request(0, 3'b100, 32'h0000_2000, 1, mk_ar(4'd0, 32'h0000_2000, 8'd3, 3'd2));
    ar_accept(0);
    ic_rd_req = 1'b1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_0040;
    dc_rd_req = 1'b1; dc_rd_type = 3'b001; dc_rd_addr = 32'h0000_3006;
    #1;
    chk("t4_ic_blocked", ic_rd_rdy, 0);
    chk("t4_dc_granted", dc_rd_rdy, 1);
    ar_q.push_back(mk_ar(4'd1, 32'h0000_3006, 8'd0, 3'd1));
    tick();
    dc_rd_req = 1'b0;
    ar_accept(0);
    chk("t4_ic_still_blocked", ic_rd_rdy, 0);
    r_beat(4'd0, 32'hB000_0000, 0, 1);
    r_beat(4'd1, 32'hC000_0000, 1, 2);
    r_beat(4'd0, 32'hB000_0001, 0, 1);
    r_beat(4'd0, 32'hB000_0002, 0, 1);
    r_drive(4'd0, 32'hB000_0003, 1, 1);
    #1;
    chk("t4_rdy_not_on_rlast", ic_rd_rdy, 0);
    tick();
    r_idle();
    chk("t4_rdy_after_rlast", ic_rd_rdy, 1);
    ar_q.push_back(mk_ar(4'd0, 32'h0000_0040, 8'd0, 3'd2));
    tick();
    ic_rd_req = 1'b0;
    ar_accept(0);
    r_beat(4'd0, 32'hB000_0040, 1, 1);

    // Reset while an AR is pending; the abandoned D-cache read's beat is dropped.
    request(1, 3'b100, 32'h0000_5000, 0, mk_ar(4'd0, 32'd0, 8'd0, 3'd0));
    chk("t6_arvalid_before", arvalid, 1);
    rst = 1'b1;
    #1;
    chk("t6_arvalid_async", arvalid, 0);
    chk("t6_fields_async", {arid, araddr, arlen, arsize}, 47'd0);
    chk("t6_rready_in_rst", rready, 0);
    tick();
    rst = 1'b0;
    tick();
    r_beat(4'd1, 32'hDEAD_0001, 1, 0);
    r_beat(4'd0, 32'hDEAD_0000, 1, 0);

    // Simultaneous requests after reset: D-cache first, then I-cache.
    ic_rd_req = 1'b1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_0100;
    dc_rd_req = 1'b1; dc_rd_type = 3'b100; dc_rd_addr = 32'h0000_0200;
    #1;
    chk("t2_dc_first", dc_rd_rdy, 1);
    chk("t2_ic_waits", ic_rd_rdy, 0);
    ar_q.push_back(mk_ar(4'd1, 32'h0000_0200, 8'd3, 3'd2));
    tick();
    dc_rd_req = 1'b0;
    ar_accept(0);
    chk("t2_ic_second", ic_rd_rdy, 1);
    ar_q.push_back(mk_ar(4'd0, 32'h0000_0100, 8'd0, 3'd2));
    tick();
    ic_rd_req = 1'b0;
    ar_accept(1);
    r_beat(4'd1, 32'hD000_0000, 0, 2);
    r_beat(4'd0, 32'hE000_0000, 1, 1);
    r_beat(4'd1, 32'hD000_0001, 0, 2);
    r_beat(4'd1, 32'hD000_0002, 0, 2);
    r_beat(4'd1, 32'hD000_0003, 1, 2);

    repeat (3) tick();
    chk("ar_q_drained", ar_q.size(), 0);
    chk("ic_q_drained", ic_q.size(), 0);
    chk("dc_q_drained", dc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
